led7_scan_driver: RTL and testbench
===================================

LED7_SCAN_DRIVER -- requirements
Module: led7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000: clk cycles per digit slot; legal minimum 2.
REQ-003 Parameter BLINK_SLOTS, default 256: number of scan ticks per blink half-period; legal minimum 1.
REQ-004 Port clk, input, 1: the block's only clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port on, input, 1: display enable; 0 forces seg and an to all zeros.
REQ-007 Port load, input, 1: capture strobe for the digits input.
REQ-008 Port digits, input, 4*N_DIGITS: hex nibbles; digit k is bits [4k+3:4k]; digit 0 is least significant.
REQ-009 Port blank_lz, input, 1: when 1, leading-zero blanking is enabled.
REQ-010 Port blink_mask, input, N_DIGITS: bit k set means digit k blinks.
REQ-011 Port seg, output, 7: segment drive, active-high; seg[0]=a through seg[6]=g.
REQ-012 Port an, output, N_DIGITS: digit select, one-hot, active-high.

Function
REQ-013 On a clk edge with load=1, the block SHALL copy digits into an internal shadow register; display logic SHALL use only the shadow register.
REQ-014 A prescaler SHALL count 0..CLK_DIV-1 and wrap, producing a one-cycle tick at count CLK_DIV-1.
REQ-015 On each tick, the digit index SHALL advance by 1; from N_DIGITS-1 it SHALL wrap to 0.
REQ-016 The prescaler and index SHALL keep running while on=0.
REQ-017 Glyph table, as hex seg values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-018 Leading-zero blanking: with blank_lz=1, digit k (k>0) SHALL be blanked (seg=00) when shadow digits k..N_DIGITS-1 are all zero; digit 0 SHALL never be blanked by this rule.
REQ-019 Blink: a blink counter SHALL count ticks; blink_phase SHALL toggle after every BLINK_SLOTS ticks; when blink_phase=1 and blink_mask[idx]=1, seg SHALL be 00.
REQ-020 During a blanked slot (REQ-018 or REQ-019), an SHALL still assert the current digit.
REQ-021 seg and an SHALL be registered; they SHALL reflect the index, shadow register and controls sampled on the previous clk edge, giving 1-cycle latency.
REQ-022 When on=1, an SHALL equal 1<<idx; when on=0, an SHALL be all zeros and seg SHALL be 00.
REQ-023 When load and a tick occur in the same cycle, the new index SHALL display the newly loaded value on the following cycle.
REQ-024 blank_lz and blink_mask SHALL be used combinationally from their live inputs; they are not shadowed.

Reset
REQ-025 While rst=1, the block SHALL hold the shadow register at 0, the prescaler at 0, idx at 0, the blink counter and blink_phase at 0, and seg and an at 0.
REQ-026 rst SHALL take priority over load and tick.
REQ-027 In the first cycle after rst is released with on=1, the block SHALL output an=0001 and seg=3F (for N_DIGITS=4).
REQ-028 A reset asserted mid-scan SHALL return idx to 0 on the next edge, without completing the current slot.

Verification (N_DIGITS=4, CLK_DIV=4, BLINK_SLOTS=2)
REQ-029 Load digits=16'h1234, on=1, blank_lz=0 -> an cycles 0001, 0010, 0100, 1000, with 4 clk per slot and seg values 66, 4F, 5B, 06 respectively, then wraps.
REQ-030 Load 16'h0070, blank_lz=1 -> digit 3 seg=00, digit 2 seg=00, digit 1 seg=07, digit 0 seg=3F; load 16'h0000 -> only digit 0 shows 3F.
REQ-031 Load 16'hABCD, set blink_mask=0001 -> digit 0 shows 5E for 2 ticks and 00 for 2 ticks, repeating; the other digits stay lit.
REQ-032 With on toggled 1->0 mid-slot -> seg=00 and an=0000 on the next cycle; on returning to 1, the scan position matches free-running counting.
REQ-033 With load=1 pulsed on the tick cycle -> the new glyph appears exactly 1 cycle later on the new digit.
REQ-034 With rst asserted at idx=2 -> next cycle seg=00 and an=0000; after release, an=0001 and seg=3F.

Source files
------------

// File: rtl/led7_scan_driver_if.sv
// Bus between a controller and the multiplexed 7-segment scan driver.
// The controller side uses the master modport and the driver uses the slave modport.
interface led7_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                  on;
    logic                  load;
    logic [4*N_DIGITS-1:0] digits;
    logic                  blank_lz;
    logic [N_DIGITS-1:0]   blink_mask;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   an;

    modport master (
        output on, load, digits, blank_lz, blink_mask,
        input  seg, an
    );

    modport slave (
        input  on, load, digits, blank_lz, blink_mask,
        output seg, an
    );
endinterface

// File: rtl/led7_scan_driver.sv
// Time-multiplexed 7-segment driver: a prescaler sets the slot rate, and each slot drives one digit.
// It supports leading-zero blanking and per-digit blinking; seg and an are registered.
module led7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int CLK_DIV     = 50000,
    parameter int BLINK_SLOTS = 256
) (
    input logic clk,
    input logic rst,
    led7_scan_driver_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = $clog2(BLINK_SLOTS + 1);

    localparam logic [PW-1:0] PS_MAX  = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BL_MAX  = BW'(BLINK_SLOTS - 1);

    logic [4*N_DIGITS-1:0] shadow;
    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         bcnt;
    logic                  phase;
    logic [6:0]            seg_q;
    logic [N_DIGITS-1:0]   an_q;

    logic                  tick;
    logic [3:0]            cur;
    logic [N_DIGITS-1:0]   upper_zero;
    logic                  zero_run;
    logic                  blank;
    logic [6:0]            glyph;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick = (presc == PS_MAX);
    assign cur  = shadow[4*idx +: 4];

    // upper_zero[k] is set when digits k through N_DIGITS-1 are all zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run & (shadow[4*k +: 4] == 4'h0);
            upper_zero[k] = zero_run;
        end
    end

    assign blank = (bus.blank_lz && (idx != '0) && upper_zero[idx])
                || (phase && bus.blink_mask[idx]);
    assign glyph = blank ? 7'h00 : hex7(cur);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            presc  <= '0;
            idx    <= '0;
            bcnt   <= '0;
            phase  <= 1'b0;
            seg_q  <= '0;
            an_q   <= '0;
        end else begin
            if (bus.load)
                shadow <= bus.digits;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                if (bcnt == BL_MAX) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            // The outputs use the pre-edge index and shadow, which gives one cycle of latency.
            seg_q <= bus.on ? glyph : 7'h00;
            an_q  <= bus.on ? (N_DIGITS'(1) << idx) : '0;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
endmodule

// File: tb/tb_led7_scan_driver.sv
// Testbench for led7_scan_driver. A model computes each cycle's expected output from elapsed-cycle arithmetic.
// A scoreboard queue separates the stimulus driver from the output monitor.
module tb_led7_scan_driver;
    localparam int N  = 4;
    localparam int CD = 4;
    localparam int BS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led7_scan_driver_if #(.N_DIGITS(N)) bus ();

    led7_scan_driver #(.N_DIGITS(N), .CLK_DIV(CD), .BLINK_SLOTS(BS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [N+6:0]   expq[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    int             n_edges = 0;
    logic [4*N-1:0] m_shadow = '0;

    // Drive one cycle of inputs at the negedge and queue the output expected after the next posedge.
    task automatic step(input logic r, input logic o, input logic ld, input logic [4*N-1:0] d,
                        input logic blz, input logic [N-1:0] msk);
        int ticks, di, ph;
        logic [3:0] nib;
        logic [6:0] s;
        logic [N-1:0] a;
        @(negedge clk);
        rst = r; bus.on = o; bus.load = ld; bus.digits = d;
        bus.blank_lz = blz; bus.blink_mask = msk;
        if (r) begin
            expq.push_back('0);
            n_edges = 0;
            m_shadow = '0;
        end else begin
            ticks = n_edges / CD;
            di    = ticks % N;
            ph    = (ticks / BS) % 2;
            nib   = 4'((m_shadow >> (4*di)) & 'hF);
            s     = font[nib];
            if (blz && di > 0 && (m_shadow >> (4*di)) == 0) s = 7'h00;
            if (ph == 1 && msk[di]) s = 7'h00;
            a = N'(1 << di);
            if (!o) begin s = 7'h00; a = '0; end
            expq.push_back({a, s});
            n_edges++;
            if (ld) m_shadow = d;
        end
    endtask

    initial begin : monitor
        logic [N+6:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if ({bus.an, bus.seg} !== e) begin
                    failures++;
                    $display("FAIL scan cyc=%0d got an=%b seg=%h want an=%b seg=%h",
                             cyc, bus.an, bus.seg, e[N+6:7], e[6:0]);
                end
            end
        end
    end

    initial begin : driver
        logic [4*N-1:0] d;
        rst = 1'b1; bus.on = 1'b0; bus.load = 1'b0; bus.digits = '0;
        bus.blank_lz = 1'b0; bus.blink_mask = '0;
        repeat (3) step(1, 1, 0, 16'h0, 0, 4'h0);
        // Check the reset state and the first cycle after release.
        step(0, 1, 0, 16'h0, 0, 4'h0);
        step(0, 1, 1, 16'h1234, 0, 4'h0);
        repeat (36) step(0, 1, 0, 16'h0, 0, 4'h0);
        step(0, 1, 1, 16'h0070, 1, 4'h0);
        repeat (20) step(0, 1, 0, 16'h0, 1, 4'h0);
        step(0, 1, 1, 16'h0000, 1, 4'h0);
        repeat (20) step(0, 1, 0, 16'h0, 1, 4'h0);
        step(0, 1, 1, 16'hABCD, 0, 4'h1);
        repeat (64) step(0, 1, 0, 16'h0, 0, 4'h1);
        // Turn on off in the middle of a slot and then back on.
        repeat (2) step(0, 1, 0, 16'h0, 0, 4'h0);
        repeat (5) step(0, 0, 0, 16'h0, 0, 4'h0);
        repeat (16) step(0, 1, 0, 16'h0, 0, 4'h0);
        // Assert reset in the middle of the scan.
        repeat (9) step(0, 1, 0, 16'h0, 0, 4'h0);
        step(1, 1, 0, 16'h0, 0, 4'h0);
        repeat (10) step(0, 1, 0, 16'h0, 0, 4'h0);
        // Issue randomized traffic: loads are sparse, data has many zero nibbles, and on/rst pulses occur occasionally.
        for (int i = 0; i < 3000; i++) begin
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0: d[15:4]  = '0;
                1: d[15:8]  = '0;
                2: d[15:12] = '0;
                default: ;
            endcase
            if ($urandom_range(0, 15) == 0) d = '0;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 7) == 0), d, 1'($urandom), 4'($urandom));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
